pixel_stream_receiver: RTL
==========================

Name: pixel_stream_receiver

Overview:
- Consumer end of the sensor pixel stream. Requests pixels from the pixel producer with `ready` and captures the returned `pixel`/`valid`.
- Buffers captured pixels in a small FIFO and forwards them downstream over a standard valid/ready interface.
- Tracks frame position, running checksum and overflow errors. Sits between the sensor-side producer and the processing block, entirely in the sensor_clk domain.

Parameters:
- IMAGE_SIZE, 1024, pixels per frame; the last pixel of a frame has index IMAGE_SIZE-1.
- FIFO_DEPTH, 8, entries in the internal buffer; power of two, minimum 4.

Ports:
- sensor_clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  start/continue requesting pixels.
- pixel  input  8  pixel from producer.
- valid  input  1  producer valid.
- ready  output  1  request to producer.
- out_pixel  output  8  head of FIFO.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accept.
- pixel_count  output  clog2(IMAGE_SIZE)+1  pixels accepted in the current frame.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_checksum  output  16  checksum of the last completed frame.
- overflow  output  1  sticky error flag.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; ready=0, out_valid=0, out_pixel=0, pixel_count=0, frame_done=0, frame_checksum=0, overflow=0, busy=0. FIFO pointers and the running sum are cleared. Reset mid-frame discards all buffered data and partial counts.
- Protocol: the producer samples `ready` at edge N and presents a new pixel with valid=1 after edge N.
  - `ready` is a registered output. `req_d` is a one-cycle delayed copy of `ready`.
  - A transfer ("accept") occurs at edge N+1 iff req_d && valid.
  - `valid` high without req_d is a held stale value and is ignored, never counted.
- Ready policy: ready=1 for the next cycle iff state==ACTIVE and the FIFO has at least 2 free entries, counted after this cycle's push and pop. This covers the in-flight request. The same rule applies when out_ready is held low.
- FIFO:
  - push on accept; pop when out_valid && out_ready.
  - Simultaneous push and pop is legal at any occupancy, including full (pop frees the slot) and empty (data passes through with one cycle latency).
  - out_pixel is the head entry and is registered/stable while out_valid && !out_ready.
  - Accept with FIFO full and no pop: sets overflow (sticky until reset), drops the pixel, and still counts it.
- Frame tracking on each accept:
  - sum <= sum + pixel, 16-bit wraparound.
  - If pixel_count == IMAGE_SIZE-1: pixel_count<=0, frame_checksum<=sum+pixel, sum<=0, frame_done=1 next cycle only.
  - Otherwise pixel_count<=pixel_count+1.
- State machine:
  - IDLE: ready=0. Goes to ACTIVE when enable=1.
  - ACTIVE: requests per the ready policy. Goes to DRAIN when enable=0; ready drops in the same cycle's registered update.
  - DRAIN: ready=0. It still accepts one in-flight pixel if req_d && valid. Goes to IDLE when req_d==0 and the FIFO is empty. If enable=1 is seen in DRAIN, it goes back to ACTIVE.
- Frame counters persist across IDLE; only reset clears them.

Decomposition:
- Package pixel_rx_pkg:
  - state enum (IDLE, ACTIVE, DRAIN);
  - CHECKSUM_W=16, PIXEL_W=8;
  - a function computing count width from IMAGE_SIZE.
- One sub-module, pixel_sync_fifo (parameterised width/depth):
  - push/pop, full/empty, free-entry count;
  - extra pointer bit for the full/empty distinction.
- Control FSM, request logic and frame tracking stay in the top.

Test Plan:
- Producer model with image[i]=i mod 256, IMAGE_SIZE=16; enable=1, out_ready=1 -> out_pixel sequence 0..15. frame_done pulses once, frame_checksum=120 (0x0078), pixel_count back to 0, overflow=0.
- Same image, two consecutive frames -> two frame_done pulses 16 accepts apart, both frame_checksum=0x0078, output continues 0..15,0..15 with no gap or duplicate.
- out_ready held 0 for 40 cycles mid-frame, FIFO_DEPTH=8 -> FIFO fills to at most 8, ready drops when free<2. No overflow, no dropped pixel, and the stream resumes in order after out_ready=1.
- enable deasserted while ready=1 -> state goes to DRAIN; exactly one in-flight pixel accepted; state goes to IDLE only after downstream empties the FIFO; stale held valid adds no extra count.
- Forced protocol violation (model asserts valid with new pixels every cycle while ready=0, with req_d bypassed via force) -> pixels ignored, count unchanged, overflow stays 0.
- rst_n asserted at pixel_count=7 with a non-empty FIFO -> all outputs at reset values immediately (asynchronous). After release with enable=1 the first out_pixel comes from the producer's restarted stream and the checksum restarts from 0.

Source files
------------

// File: rtl/pixel_rx_pkg.sv
// Shared constants for the sensor pixel receive path.
// The FSM encoding stays as plain constants so legacy blocks can compare against it directly.
package pixel_rx_pkg;

  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned CHECKSUM_W = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  // Wide enough to hold 0..IMAGE_SIZE inclusive.
  function automatic int unsigned count_width(input int unsigned image_size);
    return $clog2(image_size) + 1;
  endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// A push while full is only taken when a pop frees the slot in the same cycle.
module pixel_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     sensor_clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, rd_ptr_q, used;
  logic             do_push, do_pop;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign free    = ptr_t'(DEPTH) - used;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge sensor_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_stream_receiver.sv
// Requests pixels from the sensor producer, buffers them and forwards them downstream,
// while tracking frame position, per-frame checksum and overflow.
module pixel_stream_receiver
  import pixel_rx_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                sensor_clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [PIXEL_W-1:0]                  pixel,
  input  logic                                valid,
  output logic                                ready,
  output logic [PIXEL_W-1:0]                  out_pixel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [count_width(IMAGE_SIZE)-1:0]  pixel_count,
  output logic                                frame_done,
  output logic [CHECKSUM_W-1:0]               frame_checksum,
  output logic                                overflow,
  output logic                                busy
);

  localparam int unsigned CW = count_width(IMAGE_SIZE);
  localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] count_t;
  typedef logic [FW-1:0] free_t;

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d, req_q;
  count_t                count_q, count_d;
  logic [CHECKSUM_W-1:0] sum_q, sum_d, chk_q, chk_d, sum_plus;
  logic                  done_q, done_d, ovf_q, ovf_d;
  logic                  accept, last;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  free_t                 fifo_free, free_next;

  assign accept    = req_q && valid;
  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = accept && (!fifo_full || fifo_pop);
  assign last      = (count_q == count_t'(IMAGE_SIZE - 1));
  assign sum_plus  = sum_q + CHECKSUM_W'(pixel);
  assign free_next = fifo_free + free_t'(fifo_pop) - free_t'(fifo_push);

  pixel_sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sensor_clk (sensor_clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .wdata      (pixel),
    .pop        (fifo_pop),
    .rdata      (out_pixel),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free       (fifo_free)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                    state_d = ACTIVE;
        else if (!req_q && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Two free slots: one for the pixel already in flight, one for this request.
    ready_d = (state_d == ACTIVE) && (free_next >= free_t'(2));
  end

  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    chk_d   = chk_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (accept && fifo_full && !fifo_pop);
    if (accept) begin
      if (last) begin
        count_d = '0;
        chk_d   = sum_plus;
        sum_d   = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + count_t'(1);
        sum_d   = sum_plus;
      end
    end
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      chk_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      req_q   <= ready_q;
      count_q <= count_d;
      sum_q   <= sum_d;
      chk_q   <= chk_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready          = ready_q;
  assign out_valid      = !fifo_empty;
  assign pixel_count    = count_q;
  assign frame_done     = done_q;
  assign frame_checksum = chk_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != IDLE);

endmodule
